// File: rtl/riscv_types.sv
// Shared FP/integer pipeline types: execute-stage control bus and the FP writeback entry.
package riscv_types;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       fp_reg_write;
    logic       mem_to_reg;
  } exe_p_mux_bus_type;

  typedef struct packed {
    logic [31:0]       result;
    exe_p_mux_bus_type bus;
  } fp_wb_entry_t;

endpackage

// File: rtl/fp_wb_fifo.sv
// Single-source synchronous FIFO for FP writeback entries; flush has priority over push/pop.
module fp_wb_fifo
  import riscv_types::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fp_wb_entry_t wdata,
  output logic         full,
  output logic         empty,
  output fp_wb_entry_t head
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  fp_wb_entry_t    mem_q [Depth];
  logic            do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(Depth));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: empty FIFOs are never presented downstream.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// Serialises per-pipeline FP results onto the single writeback port with round-robin arbitration.
module fp_wb_arbiter
  import riscv_types::*;
#(
  parameter int unsigned  NUM_SRC    = 3,
  parameter int unsigned  FIFO_DEPTH = 2,
  localparam int unsigned SRC_W      = $clog2(NUM_SRC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [NUM_SRC-1:0] src_valid,
  input  logic [31:0]       src_result [NUM_SRC],
  input  exe_p_mux_bus_type src_bus    [NUM_SRC],
  output logic [NUM_SRC-1:0] src_stall,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [31:0]       wb_result,
  output exe_p_mux_bus_type wb_bus,
  output logic [SRC_W-1:0]  wb_src
);

  logic [NUM_SRC-1:0] full, empty, push, pop;
  fp_wb_entry_t       head [NUM_SRC];
  logic [SRC_W-1:0]   rr_q, rr_d, grant_q, grant_d, rr_grant, grant;
  logic               hold_q, hold_d, found;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fp_wb_entry_t wdata;
    assign wdata   = '{result: src_result[i], bus: src_bus[i]};
    assign push[i] = src_valid[i] && !full[i];
    assign pop[i]  = wb_valid && wb_ready && (grant == SRC_W'(i));

    fp_wb_fifo #(
      .Depth(FIFO_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .flush(flush),
      .push (push[i]),
      .pop  (pop[i]),
      .wdata(wdata),
      .full (full[i]),
      .empty(empty[i]),
      .head (head[i])
    );

`ifndef SYNTHESIS
    a_no_push_while_stalled : assert property (@(posedge clk) disable iff (!rst_n)
      !(src_valid[i] && src_stall[i]));
`endif
  end

  assign src_stall = full;
  assign wb_valid  = |(~empty);

  // First non-empty FIFO starting at rr, wrapping modulo NUM_SRC.
  always_comb begin
    found    = 1'b0;
    rr_grant = '0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      if (!found && !empty[(int'(rr_q) + k) % int'(NUM_SRC)]) begin
        found    = 1'b1;
        rr_grant = SRC_W'((int'(rr_q) + k) % int'(NUM_SRC));
      end
    end
  end

  // A stalled presentation stays locked to its source until accepted.
  assign grant = hold_q ? grant_q : rr_grant;

  assign wb_result = wb_valid ? head[grant].result : '0;
  assign wb_bus    = wb_valid ? head[grant].bus : '0;
  assign wb_src    = wb_valid ? grant : '0;

  always_comb begin
    rr_d    = rr_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    if (flush) begin
      rr_d    = '0;
      hold_d  = 1'b0;
      grant_d = '0;
    end else if (wb_valid) begin
      if (wb_ready) begin
        rr_d   = (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
        hold_d = 1'b0;
      end else begin
        hold_d  = 1'b1;
        grant_d = grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= '0;
      hold_q  <= 1'b0;
      grant_q <= '0;
    end else begin
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Scoreboard bench for fp_wb_arbiter: directed stimulus, monitor checks every accepted writeback.
module tb_fp_wb_arbiter;
  import riscv_types::*;

  localparam int NS = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              wb_ready = 1'b0;
  logic [NS-1:0]     src_valid = '0;
  logic [NS-1:0]     src_stall;
  logic [31:0]       src_result [NS];
  exe_p_mux_bus_type src_bus [NS];
  logic              wb_valid;
  logic [31:0]       wb_result;
  exe_p_mux_bus_type wb_bus;
  logic [1:0]        wb_src;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] qr [NS][$];
  logic [4:0]  qd [NS][$];
  int          exp_src [$];

  fp_wb_arbiter #(
    .NUM_SRC   (NS),
    .FIFO_DEPTH(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .src_valid (src_valid),
    .src_result(src_result),
    .src_bus   (src_bus),
    .src_stall (src_stall),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_result (wb_result),
    .wb_bus    (wb_bus),
    .wb_src    (wb_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pending();
    return qr[0].size() + qr[1].size() + qr[2].size();
  endfunction

  task automatic clear_queues();
    for (int i = 0; i < NS; i++) begin
      qr[i].delete();
      qd[i].delete();
    end
    exp_src.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input int i, input logic [31:0] r, input logic [4:0] rd);
    src_valid[i]  = 1'b1;
    src_result[i] = r;
    src_bus[i]    = '{rd: rd, reg_write: 1'b0, fp_reg_write: 1'b1, mem_to_reg: 1'b0};
    qr[i].push_back(r);
    qd[i].push_back(rd);
  endtask

  task automatic do_flush();
    src_valid = '0;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    clear_queues();
  endtask

  task automatic drain(input string name, input int max_cycles);
    src_valid = '0;
    wb_ready  = 1'b1;
    for (int k = 0; k < max_cycles; k++) begin
      if (pending() == 0) break;
      tick();
    end
    chk(name, pending(), 0);
  endtask

  // Monitor: every accepted writeback must match the head of its source's expected queue.
  always @(negedge clk) begin
    if (rst_n && !flush && wb_valid && wb_ready) begin
      if (wb_src >= 2'(NS) || qr[wb_src].size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected writeback: src %0d result %h, expected none", wb_src, wb_result);
      end else begin
        chk("wb_result", wb_result, qr[wb_src].pop_front());
        chk("wb_bus.rd", 32'(wb_bus.rd), 32'(qd[wb_src].pop_front()));
      end
      if (exp_src.size() > 0) chk("wb_src order", 32'(wb_src), 32'(exp_src.pop_front()));
    end
  end

  initial begin
    for (int i = 0; i < NS; i++) begin
      src_result[i] = '0;
      src_bus[i]    = '0;
    end

    // Reset state
    #12;
    chk("reset wb_valid", 32'(wb_valid), 0);
    chk("reset src_stall", 32'(src_stall), 0);
    chk("reset wb_result", wb_result, 0);
    chk("reset wb_src", 32'(wb_src), 0);
    chk("reset wb_bus", 32'(wb_bus), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single push, one-cycle latency
    wb_ready = 1'b1;
    drive_push(0, 32'h4040_0000, 5'd5);
    exp_src.push_back(0);
    tick();
    src_valid = '0;
    @(negedge clk);
    chk("single wb_valid", 32'(wb_valid), 1);
    chk("single wb_result", wb_result, 32'h4040_0000);
    chk("single wb_bus.rd", 32'(wb_bus.rd), 5);
    chk("single wb_src", 32'(wb_src), 0);
    tick();
    @(negedge clk);
    chk("single after pop wb_valid", 32'(wb_valid), 0);

    // Fairness: all sources offered every cycle
    tick();
    do_flush();
    wb_ready = 1'b1;
    for (int r = 0; r < 3; r++) for (int s = 0; s < NS; s++) exp_src.push_back(s);
    for (int c = 0; c < 12; c++) begin
      src_valid = '0;
      for (int i = 0; i < NS; i++)
        if (!src_stall[i]) drive_push(i, 32'h3f80_0000 + 32'(i << 8) + 32'(c), 5'(i * 8 + c % 8));
      tick();
    end
    drain("fairness drained", 30);
    chk("fairness order consumed", exp_src.size(), 0);

    // Backpressure: fill src1, hold presentation, no preemption by src0
    do_flush();
    wb_ready = 1'b0;
    drive_push(1, 32'h4100_0001, 5'd11);
    tick();
    src_valid = '0;
    drive_push(1, 32'h4100_0002, 5'd12);
    @(negedge clk);
    chk("bp stall after 1 push", 32'(src_stall[1]), 0);
    chk("bp src", 32'(wb_src), 1);
    tick();
    src_valid = '0;
    drive_push(0, 32'h4200_0000, 5'd20);
    @(negedge clk);
    chk("bp stall after 2 pushes", 32'(src_stall[1]), 1);
    chk("bp hold result", wb_result, 32'h4100_0001);
    chk("bp hold src", 32'(wb_src), 1);
    for (int c = 0; c < 2; c++) begin
      tick();
      src_valid = '0;
      @(negedge clk);
      chk("bp no preempt src", 32'(wb_src), 1);
      chk("bp stable result", wb_result, 32'h4100_0001);
      chk("bp stall held", 32'(src_stall[1]), 1);
    end
    tick();
    wb_ready = 1'b1;
    exp_src.push_back(1);
    exp_src.push_back(0);
    exp_src.push_back(1);
    @(negedge clk);
    chk("bp stall same-cycle pop", 32'(src_stall[1]), 1);
    tick();
    @(negedge clk);
    chk("bp stall lifted", 32'(src_stall[1]), 0);
    drain("bp drained", 10);

    // Push+pop steady state and pointer wrap on src2
    do_flush();
    wb_ready = 1'b0;
    drive_push(2, 32'h4300_0000, 5'd1);
    tick();
    src_valid = '0;
    drive_push(2, 32'h4300_0001, 5'd2);
    tick();
    src_valid = '0;
    wb_ready  = 1'b1;
    for (int k = 0; k < 12; k++) exp_src.push_back(2);
    @(negedge clk);
    chk("wrap full stall", 32'(src_stall[2]), 1);
    chk("wrap full valid", 32'(wb_valid), 1);
    for (int it = 0; it < 10; it++) begin
      tick();
      src_valid = '0;
      if (!src_stall[2]) drive_push(2, 32'h4400_0000 + 32'(it), 5'(it + 3));
      @(negedge clk);
      chk("wrap steady stall", 32'(src_stall[2]), 0);
    end
    tick();
    drain("wrap drained", 10);
    chk("wrap order consumed", exp_src.size(), 0);

    // Flush discards buffered entries and a same-cycle push
    do_flush();
    wb_ready = 1'b0;
    drive_push(0, 32'h4500_0000, 5'd7);
    drive_push(1, 32'h4600_0000, 5'd8);
    tick();
    drive_push(0, 32'h4500_0001, 5'd9);
    drive_push(1, 32'h4600_0001, 5'd10);
    tick();
    src_valid     = '0;
    flush         = 1'b1;
    wb_ready      = 1'b1;
    src_valid[2]  = 1'b1;
    src_result[2] = 32'hdead_beef;
    tick();
    flush     = 1'b0;
    src_valid = '0;
    clear_queues();
    @(negedge clk);
    chk("flush wb_valid", 32'(wb_valid), 0);
    chk("flush src_stall", 32'(src_stall), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      chk("flush nothing reappears", 32'(wb_valid), 0);
    end

    // Asynchronous reset with a full FIFO buffered
    tick();
    wb_ready = 1'b0;
    drive_push(0, 32'h4700_0000, 5'd13);
    tick();
    src_valid = '0;
    drive_push(0, 32'h4700_0001, 5'd14);
    tick();
    src_valid = '0;
    @(negedge clk);
    chk("pre-reset stall", 32'(src_stall[0]), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset wb_valid", 32'(wb_valid), 0);
    chk("async reset src_stall", 32'(src_stall), 0);
    chk("async reset wb_result", wb_result, 0);
    clear_queues();
    tick();
    rst_n    = 1'b1;
    wb_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post-reset no stale", 32'(wb_valid), 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
